pic_host_bus_master: RTL

Host-side bus initiator for the 8259A PIC: turns a simple valid/ready command stream into correctly timed CS/RD/WR/A0 bus cycles. It drives the 8259A data bus for writes (ICW/OCW programming) and captures it for reads (IRR/ISR/IMR status). It sits between the system controller and the PIC's bus control logic, and is the initiating end of the interface whose responder decodes these cycles into ICW/OCW write strobes. Optionally, it runs the ICW initialization sequence autonomously after reset.

---
 rtl/pic_bus_pkg.sv | 44 ++++
 rtl/pic_bus_phase_timer.sv | 32 +++
 rtl/pic_host_bus_master.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pic_bus_pkg.sv
// Shared types and constants for the 8259A host bus master.
// State encoding, A0 meanings, ICW1 bit positions, phase counter width,
// and the helper that walks the optional ICW init sequence.
package pic_bus_pkg;

  localparam int PHASE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_STROBE    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_INIT_LOAD = 3'd4
  } bus_state_e;

  localparam logic A0_CMD  = 1'b0;
  localparam logic A0_DATA = 1'b1;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_INIT = 4;

  // Init word index: 0=ICW1, 1=ICW2, 2=ICW3, 3=ICW4, 4=sequence finished.
  typedef logic [2:0] init_idx_t;
  localparam init_idx_t INIT_IDX_DONE = 3'd4;

  // Next ICW to send after idx; ICW3 only in cascade mode, ICW4 only when IC4 set.
  function automatic init_idx_t icw_next(input init_idx_t idx, input logic [7:0] icw1);
    init_idx_t nxt;
    nxt = INIT_IDX_DONE;
    case (idx)
      3'd0: nxt = 3'd1;
      3'd1: begin
        if (!icw1[ICW1_SNGL])    nxt = 3'd2;
        else if (icw1[ICW1_IC4]) nxt = 3'd3;
        else                     nxt = INIT_IDX_DONE;
      end
      3'd2: nxt = icw1[ICW1_IC4] ? 3'd3 : INIT_IDX_DONE;
      default: nxt = INIT_IDX_DONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pic_bus_phase_timer.sv
// Loadable down-counter timing each bus phase; tc is high when the
// count reaches zero, i.e. in the last cycle of the current phase.
module pic_bus_phase_timer
  import pic_bus_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_value,
  output logic               tc
);

  localparam logic [PHASE_W-1:0] ONE = {{(PHASE_W-1){1'b0}}, 1'b1};

  logic [PHASE_W-1:0] cnt_q, cnt_d;

  // Load on phase entry, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_value;
    else if (cnt_q != '0)   cnt_d = cnt_q - ONE;
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/pic_host_bus_master.sv
// Host-side 8259A bus initiator: valid/ready commands in, CS/RD/WR/A0
// cycles out (SETUP -> STROBE -> HOLD -> IDLE).
// Optional feature macro: PIC_HOST_INIT_SEQ_EN runs the ICW sequence after reset.
// Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready;
// cmd_ready is only high in IDLE once init is done. rsp_valid is a one-cycle
// pulse with no back-pressure. Debug: FSM state is visible as state_q.
module pic_host_bus_master
  import pic_bus_pkg::*;
#(
  parameter int         SETUP_CYCLES  = 1,
  parameter int         STROBE_CYCLES = 2,
  parameter int         HOLD_CYCLES   = 1,
  parameter logic [7:0] ICW1 = 8'h13,
  parameter logic [7:0] ICW2 = 8'h20,
  parameter logic [7:0] ICW3 = 8'h00,
  parameter logic [7:0] ICW4 = 8'h01
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_address,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       init_done,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       address,
  output logic [7:0] data_bus_out,
  output logic       data_bus_oe,
  input  logic [7:0] data_bus_in
);

  localparam logic [PHASE_W-1:0] SETUP_LD  = PHASE_W'(SETUP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] STROBE_LD = PHASE_W'(STROBE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LD   = PHASE_W'(HOLD_CYCLES - 1);

  bus_state_e         state_q, state_d;
  logic               wr_q, wr_d;
  logic               addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [7:0]         cap_q, cap_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               tmr_load;
  logic [PHASE_W-1:0] tmr_value;
  logic               tmr_tc;
  logic               init_done_w;

`ifdef PIC_HOST_INIT_SEQ_EN
  logic      init_done_q, init_done_d;
  init_idx_t idx_q, idx_d;
  logic      last_q, last_d;
  assign init_done_w = init_done_q;
`else
  logic unused_icw;
  assign unused_icw  = ^{ICW1, ICW2, ICW3, ICW4};
  assign init_done_w = 1'b1;
`endif

  pic_bus_phase_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tc         (tmr_tc)
  );

  // Next-state: phase sequencing, command latch, read capture and response.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cap_d       = cap_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;
`ifdef PIC_HOST_INIT_SEQ_EN
    init_done_d = init_done_q;
    idx_d       = idx_q;
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && init_done_w) begin
          wr_d      = cmd_write;
          addr_d    = cmd_address;
          data_d    = cmd_data;
          state_d   = ST_SETUP;
          tmr_load  = 1'b1;
          tmr_value = SETUP_LD;
        end
`ifdef PIC_HOST_INIT_SEQ_EN
        else if (!init_done_q) begin
          state_d = ST_INIT_LOAD;
        end
`endif
      end
      ST_INIT_LOAD: begin
`ifdef PIC_HOST_INIT_SEQ_EN
        wr_d      = 1'b1;
        addr_d    = (idx_q == 3'd0) ? A0_CMD : A0_DATA;
        data_d    = (idx_q == 3'd0) ? ICW1 :
                    (idx_q == 3'd1) ? ICW2 :
                    (idx_q == 3'd2) ? ICW3 : ICW4;
        idx_d     = icw_next(idx_q, ICW1);
        last_d    = (icw_next(idx_q, ICW1) == INIT_IDX_DONE);
        state_d   = ST_SETUP;
        tmr_load  = 1'b1;
        tmr_value = SETUP_LD;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_d   = ST_STROBE;
          tmr_load  = 1'b1;
          tmr_value = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (tmr_tc) begin
          if (!wr_q) cap_d = data_bus_in;
          state_d   = ST_HOLD;
          tmr_load  = 1'b1;
          tmr_value = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_tc) begin
          state_d = ST_IDLE;
          if (!wr_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = cap_q;
          end
`ifdef PIC_HOST_INIT_SEQ_EN
          if (!init_done_q && last_q) init_done_d = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= 1'b0;
      data_q      <= '0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef PIC_HOST_INIT_SEQ_EN
      init_done_q <= 1'b0;
      idx_q       <= '0;
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef PIC_HOST_INIT_SEQ_EN
      init_done_q <= init_done_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
`endif
    end
  end

  // Bus outputs decoded from state; strobes are mutually exclusive by construction.
  always_comb begin
    CS           = 1'b1;
    RD           = 1'b1;
    WR           = 1'b1;
    data_bus_oe  = 1'b0;
    address      = addr_q;
    data_bus_out = data_q;
    cmd_ready    = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready = init_done_w;
      ST_SETUP, ST_HOLD: begin
        CS          = 1'b0;
        data_bus_oe = wr_q;
      end
      ST_STROBE: begin
        CS          = 1'b0;
        WR          = ~wr_q;
        RD          = wr_q;
        data_bus_oe = wr_q;
      end
      default: ;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_done = init_done_w;

endmodule
